// File: rtl/adc_scan_ctrl.sv
// AD7928 multi-channel scan controller: issues 16-bit SPI control frames, walks the enabled
// channel subset, tags results by the ADC's returned address and keeps a per-channel bank.
// Optional build macro ADC_AVG_EN: bank entries hold the mean of every 4 samples of a channel.
module adc_scan_ctrl #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned SCLK_DIV     = 2,
  parameter int unsigned QUIET_CYCLES = 3,
  parameter logic        CODING       = 1'b1,
  parameter logic        RANGE        = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [7:0]           ch_mask,
  output logic                 ADC_CS_N,
  output logic                 ADC_SCLK,
  output logic                 ADC_DIN,
  input  logic                 ADC_DOUT,
  output logic                 sample_valid,
  output logic [2:0]           sample_ch,
  output logic [11:0]          sample_data,
  output logic                 scan_done,
  output logic [NUM_CH*12-1:0] data_flat
);

  localparam int unsigned CntMax = (SCLK_DIV > QUIET_CYCLES) ? SCLK_DIV : QUIET_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [7:0]  ChValid = 8'((16'd1 << NUM_CH) - 16'd1);

  typedef enum logic [1:0] {StIdle, StQuiet, StShiftLo, StShiftHi} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      dummy_q, dummy_d;
  logic            discard_q, discard_d;
  logic            result_q, result_d;
  logic [2:0]      cur_q, cur_d;
  logic [7:0]      mask_q, mask_d;
  logic [15:0]     tx_q, tx_d;
  logic [13:0]     rx_q, rx_d;
  logic            cs_n_q, cs_n_d, sclk_q, sclk_d, din_q, din_d;
  logic            valid_q, valid_d, done_q, done_d;
  logic [2:0]      ch_q, ch_d;
  logic [11:0]     data_q, data_d;
  logic [11:0]     res_q [NUM_CH];
  logic            res_wr;

  logic [7:0]  mask_eff;
  logic        start_ok;
  logic [2:0]  lo_addr, nxt_addr, hi_addr;
  logic        hit_lo, hit_nxt;
  logic [14:0] rx_next;
  logic [2:0]  rx_ch;
  logic [15:0] ctrl_word;

  assign mask_eff  = ch_mask & ChValid;
  assign start_ok  = enable && (mask_eff != 8'd0);
  assign rx_next   = {rx_q, ADC_DOUT};
  assign rx_ch     = rx_next[14:12];
  assign ctrl_word = {3'b100, nxt_addr, 2'b11, 2'b00, RANGE, CODING, 4'b0000};

  // Next address: lowest enabled channel above the last issued one, else wrap to lowest.
  always_comb begin
    lo_addr  = 3'd0;
    nxt_addr = 3'd0;
    hit_lo   = 1'b0;
    hit_nxt  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mask_eff[i] && !hit_lo) begin
        lo_addr = 3'(i);
        hit_lo  = 1'b1;
      end
      if (mask_eff[i] && (i > int'(cur_q)) && !hit_nxt) begin
        nxt_addr = 3'(i);
        hit_nxt  = 1'b1;
      end
    end
    if (!hit_nxt) nxt_addr = lo_addr;
  end

  // Highest channel of the mask latched at the start of the frame being published.
  always_comb begin
    hi_addr = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask_q[i]) hi_addr = 3'(i);
    end
  end

  // Frame sequencer: next-state, serial outputs and result strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    bit_d     = bit_q;
    dummy_d   = dummy_q;
    discard_d = discard_q;
    result_d  = result_q;
    cur_d     = cur_q;
    mask_d    = mask_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cs_n_d    = cs_n_q;
    din_d     = din_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    ch_d      = ch_q;
    data_d    = data_q;
    res_wr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StQuiet;
          cnt_d   = CntW'(QUIET_CYCLES - 1);
        end
      end
      StQuiet: begin
        if (cnt_q == '0) begin
          if (start_ok) begin
            state_d = StShiftLo;
            cnt_d   = CntW'(SCLK_DIV - 1);
            cs_n_d  = 1'b0;
            bit_d   = 4'd0;
            mask_d  = mask_eff;
            if (dummy_q != 2'd0) begin
              // Power-up frames: DIN held high so the ADC leaves shutdown.
              dummy_d  = dummy_q - 2'd1;
              result_d = 1'b0;
              din_d    = 1'b1;
              tx_d     = 16'hFFFF;
            end else begin
              cur_d     = nxt_addr;
              result_d  = !discard_q;
              discard_d = 1'b0;
              din_d     = ctrl_word[15];
              tx_d      = {ctrl_word[14:0], 1'b0};
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      StShiftLo: begin
        if (cnt_q == '0) begin
          state_d = StShiftHi;
          cnt_d   = CntW'(SCLK_DIV - 1);
        end
      end
      StShiftHi: begin
        if (cnt_q == '0) begin
          rx_d = rx_next[13:0];
          if (bit_q == 4'd15) begin
            state_d = StQuiet;
            cnt_d   = CntW'(QUIET_CYCLES - 1);
            cs_n_d  = 1'b1;
            din_d   = 1'b0;
            if (result_q && (int'(rx_ch) < NUM_CH)) begin
              valid_d = 1'b1;
              done_d  = (rx_ch == hi_addr);
              ch_d    = rx_ch;
              data_d  = rx_next[11:0];
              res_wr  = 1'b1;
            end
          end else begin
            state_d = StShiftLo;
            cnt_d   = CntW'(SCLK_DIV - 1);
            bit_d   = bit_q + 4'd1;
            din_d   = tx_q[15];
            tx_d    = {tx_q[14:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
    sclk_d = (state_d != StShiftLo);
  end

  // Sequencer state; reset restarts the dummy-frame sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StQuiet;
      cnt_q     <= CntW'(QUIET_CYCLES - 1);
      bit_q     <= 4'd0;
      dummy_q   <= 2'd2;
      discard_q <= 1'b1;
      result_q  <= 1'b0;
      cur_q     <= 3'd7;
      mask_q    <= 8'd0;
      tx_q      <= 16'd0;
      rx_q      <= 14'd0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ch_q      <= 3'd0;
      data_q    <= 12'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      dummy_q   <= dummy_d;
      discard_q <= discard_d;
      result_q  <= result_d;
      cur_q     <= cur_d;
      mask_q    <= mask_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
    end
  end

`ifdef ADC_AVG_EN
  logic [13:0] acc_q [NUM_CH];
  logic [1:0]  cnt4_q [NUM_CH];

  // Result bank: each channel publishes the mean of every four samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        res_q[i]  <= 12'd0;
        acc_q[i]  <= 14'd0;
        cnt4_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (res_wr && (rx_ch == 3'(i))) begin
          if (cnt4_q[i] == 2'd3) begin
            res_q[i]  <= 12'((acc_q[i] + {2'b00, rx_next[11:0]}) >> 2);
            acc_q[i]  <= 14'd0;
            cnt4_q[i] <= 2'd0;
          end else begin
            acc_q[i]  <= acc_q[i] + {2'b00, rx_next[11:0]};
            cnt4_q[i] <= cnt4_q[i] + 2'd1;
          end
        end
      end
    end
  end
`else
  // Result bank: latest raw sample per channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= 12'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (res_wr && (rx_ch == 3'(i))) res_q[i] <= rx_next[11:0];
      end
    end
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign data_flat[g*12 +: 12] = res_q[g];
  end

  assign ADC_CS_N     = cs_n_q;
  assign ADC_SCLK     = sclk_q;
  assign ADC_DIN      = din_q;
  assign sample_valid = valid_q;
  assign sample_ch    = ch_q;
  assign sample_data  = data_q;
  assign scan_done    = done_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a behavioural AD7928 model on the default instance
// and a second instance (SCLK_DIV=4, QUIET_CYCLES=2) used for SPI timing only.
module tb_adc_scan_ctrl;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable  = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        adc_dout = 1'b0;

  logic        ADC_CS_N, ADC_SCLK, ADC_DIN;
  logic        sample_valid, scan_done;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;
  logic [95:0] data_flat;

  logic        cs2_n, sclk2, din2, valid2, done2;
  logic [2:0]  ch2;
  logic [11:0] data2;
  logic [95:0] flat2;

  always #10 clock = ~clock;

  adc_scan_ctrl dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK), .ADC_DIN(ADC_DIN), .ADC_DOUT(adc_dout),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .scan_done(scan_done), .data_flat(data_flat)
  );

  adc_scan_ctrl #(.SCLK_DIV(4), .QUIET_CYCLES(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .ADC_CS_N(cs2_n), .ADC_SCLK(sclk2), .ADC_DIN(din2), .ADC_DOUT(1'b0),
    .sample_valid(valid2), .sample_ch(ch2), .sample_data(data2),
    .scan_done(done2), .data_flat(flat2)
  );

  int npass = 0;
  int nfail = 0;
  int nchk  = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // AD7928 model: returns the address written in the previous full frame.
  logic [15:0] din_sr = 16'd0;
  logic [15:0] dout_sr = 16'd0;
  int          rise_cnt = 0;
  logic [2:0]  prev_addr = 3'd7;
  logic [15:0] frame_words[$];
  int          frame_rises[$];
  bit          avg_mode = 1'b0;
  int          avg_base = 0;

  always @(negedge ADC_CS_N) begin
    rise_cnt <= 0;
    adc_dout <= 1'b0;
    if (avg_mode) dout_sr <= {1'b0, prev_addr, 12'(97 + frame_words.size() - avg_base)};
    else          dout_sr <= {1'b0, prev_addr, 12'(prev_addr) * 12'h111};
  end

  always @(posedge ADC_SCLK) begin
    if (!ADC_CS_N && rise_cnt < 16) begin
      adc_dout <= dout_sr[4'(15 - rise_cnt)];
      din_sr[4'(15 - rise_cnt)] <= ADC_DIN;
      rise_cnt <= rise_cnt + 1;
    end
  end

  always @(posedge ADC_CS_N) begin
    if (rise_cnt > 0) begin
      frame_words.push_back(din_sr);
      frame_rises.push_back(rise_cnt);
      if (rise_cnt == 16) prev_addr <= din_sr[12:10];
    end
  end

  // Cycle-stamped CS falls and SCLK run lengths, sampled on the falling clock edge.
  int   cyc = 0;
  int   cs_falls[$];
  int   cs2_falls[$];
  logic cs_prev = 1'b1, cs2_prev = 1'b1, sclk2_prev = 1'b1;
  int   run2 = 0, lo2 = 0, hi2 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (cs_prev && !ADC_CS_N) cs_falls.push_back(cyc);
    if (cs2_prev && !cs2_n) cs2_falls.push_back(cyc);
    if (sclk2 === sclk2_prev) run2 <= run2 + 1;
    else begin
      if (!cs2_prev && !cs2_n) begin
        if (!sclk2_prev) lo2 <= run2;
        else             hi2 <= run2;
      end
      run2 <= 1;
    end
    cs_prev    <= ADC_CS_N;
    cs2_prev   <= cs2_n;
    sclk2_prev <= sclk2;
  end

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (sample_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_bit(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (!ADC_CS_N && !ADC_SCLK && rise_cnt == idx) ok = 1'b1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int exp_seq [4] = '{0, 2, 0, 2};

  initial begin
    bit ok;
    int n0, n1, bad, nv;

    // Reset state
    enable  = 1'b1;
    ch_mask = 8'h01;
    #1 reset_n = 1'b0;
    #24;
    chk("rst_cs_n", 96'(ADC_CS_N), 96'(1));
    chk("rst_sclk", 96'(ADC_SCLK), 96'(1));
    chk("rst_din", 96'(ADC_DIN), 96'(0));
    chk("rst_valid", 96'(sample_valid), 96'(0));
    chk("rst_done", 96'(scan_done), 96'(0));
    chk("rst_ch", 96'(sample_ch), 96'(0));
    chk("rst_data", 96'(sample_data), 96'(0));
    chk("rst_flat", data_flat, 96'(0));
    @(negedge clock);
    reset_n = 1'b1;

    // Two dummy frames, one discard frame, first result at end of frame 4
    wait_valid(400, ok);
    chk("first_valid_seen", 96'(ok), 96'(1));
    chk("first_valid_frames", 96'(frame_words.size()), 96'(4));
    chk("first_valid_cs_high", 96'(ADC_CS_N), 96'(1));
    chk("dummy0_din", 96'(frame_words[0]), 96'(16'hFFFF));
    chk("dummy1_din", 96'(frame_words[1]), 96'(16'hFFFF));
    chk("dummy0_sclks", 96'(frame_rises[0]), 96'(16));
    chk("ctrl_word_ch0", 96'(frame_words[2]), 96'(16'h8310));
    chk("frame_period", 96'(cs_falls[1] - cs_falls[0]), 96'(67));
    chk("first_ch", 96'(sample_ch), 96'(0));
    chk("first_done", 96'(scan_done), 96'(1));
    chk("div4_period", 96'(cs2_falls[1] - cs2_falls[0]), 96'(130));
    chk("div4_sclk_lo", 96'(lo2), 96'(4));
    chk("div4_sclk_hi", 96'(hi2), 96'(4));

    // Mask 0x05: results alternate 0,2; scan_done only with channel 2
    ch_mask = 8'h05;
    for (int k = 0; k < 4; k++) begin
      wait_valid(200, ok);
      chk("seq_valid_seen", 96'(ok), 96'(1));
      chk("seq_ch", 96'(sample_ch), 96'(exp_seq[k]));
      chk("seq_data", 96'(sample_data), 96'(exp_seq[k] * 32'h111));
      chk("seq_done", 96'(scan_done), 96'(exp_seq[k] == 2));
    end
`ifndef ADC_AVG_EN
    chk("flat_ch2", 96'(data_flat[35:24]), 96'(12'h222));
`endif
    chk("issued_f4", 96'(frame_words[4]), 96'(16'h8B10));
    chk("issued_f5_addr", 96'(frame_words[5][12:10]), 96'(0));
    chk("issued_f6_addr", 96'(frame_words[6][12:10]), 96'(2));
    chk("issued_f7_addr", 96'(frame_words[7][12:10]), 96'(0));

    // enable dropped during bit 7: frame completes and publishes, then idle
    wait_bit(7, 300, ok);
    chk("reach_bit7", 96'(ok), 96'(1));
    enable = 1'b0;
    n0 = frame_words.size();
    wait_valid(200, ok);
    chk("endrop_valid_seen", 96'(ok), 96'(1));
    chk("endrop_sclks", 96'(frame_rises[n0]), 96'(16));
    chk("endrop_ch", 96'(sample_ch), 96'(0));
    chk("endrop_done", 96'(scan_done), 96'(0));
    bad = 0;
    nv  = 0;
    repeat (200) begin
      @(negedge clock);
      if (!ADC_CS_N || !ADC_SCLK) bad++;
      if (sample_valid) nv++;
    end
    chk("idle_pins_hold", 96'(bad), 96'(0));
    chk("idle_no_valid", 96'(nv), 96'(0));
    chk("idle_no_frames", 96'(frame_words.size()), 96'(n0 + 1));
    enable = 1'b1;
    wait_valid(300, ok);
    chk("reen_valid_seen", 96'(ok), 96'(1));
    chk("reen_word", 96'(frame_words[n0 + 1]), 96'(16'h8310));
    chk("reen_ch", 96'(sample_ch), 96'(2));
    chk("reen_data", 96'(sample_data), 96'(12'h222));
    chk("reen_done", 96'(scan_done), 96'(1));

    // Reset during bit 9, checked before any clock edge
    wait_bit(9, 300, ok);
    chk("reach_bit9", 96'(ok), 96'(1));
    reset_n = 1'b0;
    #2;
    chk("arst_cs_n", 96'(ADC_CS_N), 96'(1));
    chk("arst_sclk", 96'(ADC_SCLK), 96'(1));
    chk("arst_flat", data_flat, 96'(0));
    chk("arst_valid", 96'(sample_valid), 96'(0));
    repeat (3) @(negedge clock);
    n1 = frame_words.size();
    chk("arst_partial", 96'(frame_rises[n1 - 1] < 16), 96'(1));
    reset_n = 1'b1;
    wait_valid(500, ok);
    chk("rerst_valid_seen", 96'(ok), 96'(1));
    chk("rerst_frames", 96'(frame_words.size()), 96'(n1 + 4));
    chk("rerst_dummy0", 96'(frame_words[n1]), 96'(16'hFFFF));
    chk("rerst_dummy1", 96'(frame_words[n1 + 1]), 96'(16'hFFFF));
    chk("rerst_ctrl", 96'(frame_words[n1 + 2]), 96'(16'h8310));
    chk("rerst_ch", 96'(sample_ch), 96'(0));

`ifdef ADC_AVG_EN
    // Averaging: ch0 samples 100..103, bank updates only on the 4th
    ch_mask = 8'h01;
    reset_n = 1'b0;
    #2;
    avg_base = frame_words.size();
    avg_mode = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(500, ok);
      chk("avg_valid_seen", 96'(ok), 96'(1));
      chk("avg_raw", 96'(sample_data), 96'(100 + k));
      chk("avg_flat", 96'(data_flat[11:0]), 96'((k < 3) ? 0 : 101));
    end
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
